// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload, zero pad, optional CRC-32 FCS, then inter-frame gap.
// Define MII_TX_FCS_EN to append the FCS; without it the frame ends after the last data/pad byte.
module mii_tx_framer #(
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_NIBBLES     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       phy_tx_en,
    output logic [3:0] phy_txd,
    output logic       tx_busy,
    output logic       tx_underrun
);
    localparam int unsigned CNT_W = (IFG_NIBBLES > 16) ? $clog2(IFG_NIBBLES) : 4;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(15);
    // The IDLE cycle that raises tx_ready is the final gap nibble, so back-to-back frames
    // are separated by exactly IFG_NIBBLES low cycles.
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_NIBBLES > 1) ? IFG_NIBBLES - 2 : 0);
    localparam logic [10:0]      CNT_MAX  = 11'h7FF;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
`ifdef MII_TX_FCS_EN
    localparam logic [2:0] S_FCS  = 3'd4;
`endif
    localparam logic [2:0] S_IFG  = 3'd5;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       byte_q, byte_n;
    logic             hi_q, hi_n;
    logic             last_q, last_n;
    logic [10:0]      byte_cnt, byte_cnt_n, byte_cnt_inc;
    logic             need_pad;
    logic             ready_n, en_n, busy_n, underrun_n;
    logic [3:0]       txd_n;

    assign byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
    assign need_pad     = 32'(byte_cnt_inc) < MIN_FRAME_BYTES;

`ifdef MII_TX_FCS_EN
    logic [31:0] crc_q, crc_n, fcs;
    logic [2:0]  fcs_idx;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs     = ~crc_q;
    assign fcs_idx = cnt[2:0] + 3'd1;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        byte_n     = byte_q;
        hi_n       = hi_q;
        last_n     = last_q;
        byte_cnt_n = byte_cnt;
        ready_n    = 1'b0;
        en_n       = 1'b0;
        txd_n      = 4'h0;
        busy_n     = tx_busy;
        underrun_n = 1'b0;
`ifdef MII_TX_FCS_EN
        crc_n      = crc_q;
`endif
        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                busy_n  = 1'b0;
                if (tx_ready && tx_data_valid) begin
                    state_n    = S_PRE;
                    cnt_n      = '0;
                    byte_n     = tx_data;
                    last_n     = tx_last;
                    hi_n       = 1'b0;
                    byte_cnt_n = '0;
`ifdef MII_TX_FCS_EN
                    crc_n      = 32'hFFFFFFFF;
`endif
                    ready_n    = 1'b0;
                    busy_n     = 1'b1;
                    en_n       = 1'b1;
                    txd_n      = 4'h5;
                end
            end
            S_PRE: begin
                en_n = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_n = S_DATA;
                    hi_n    = 1'b0;
                    txd_n   = byte_q[3:0];
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    txd_n = (cnt_n == PRE_LAST) ? 4'hD : 4'h5;
                end
            end
            S_DATA, S_PAD: begin
                if (!hi_q) begin
                    hi_n    = 1'b1;
                    en_n    = 1'b1;
                    txd_n   = byte_q[7:4];
                    ready_n = (state == S_DATA) && !last_q;
                end else begin
                    byte_cnt_n = byte_cnt_inc;
`ifdef MII_TX_FCS_EN
                    crc_n      = crc_byte(crc_q, byte_q);
`endif
                    if (state == S_DATA && !last_q) begin
                        if (tx_data_valid) begin
                            byte_n = tx_data;
                            last_n = tx_last;
                            hi_n   = 1'b0;
                            en_n   = 1'b1;
                            txd_n  = tx_data[3:0];
                        end else begin
                            underrun_n = 1'b1;
                            state_n    = S_IFG;
                            cnt_n      = '0;
                        end
                    end else if (need_pad) begin
                        state_n = S_PAD;
                        byte_n  = 8'h00;
                        hi_n    = 1'b0;
                        en_n    = 1'b1;
                    end else begin
`ifdef MII_TX_FCS_EN
                        state_n = S_FCS;
                        cnt_n   = '0;
                        en_n    = 1'b1;
                        txd_n   = ~crc_n[3:0];
`else
                        state_n = S_IFG;
                        cnt_n   = '0;
`endif
                    end
                end
            end
`ifdef MII_TX_FCS_EN
            S_FCS: begin
                if (cnt[2:0] == 3'd7) begin
                    state_n = S_IFG;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    en_n  = 1'b1;
                    txd_n = fcs[{fcs_idx, 2'b00} +: 4];
                end
            end
`endif
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            byte_q      <= '0;
            hi_q        <= 1'b0;
            last_q      <= 1'b0;
            byte_cnt    <= '0;
            tx_ready    <= 1'b0;
            phy_tx_en   <= 1'b0;
            phy_txd     <= 4'h0;
            tx_busy     <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef MII_TX_FCS_EN
            crc_q       <= 32'hFFFFFFFF;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            byte_q      <= byte_n;
            hi_q        <= hi_n;
            last_q      <= last_n;
            byte_cnt    <= byte_cnt_n;
            tx_ready    <= ready_n;
            phy_tx_en   <= en_n;
            phy_txd     <= txd_n;
            tx_busy     <= busy_n;
            tx_underrun <= underrun_n;
`ifdef MII_TX_FCS_EN
            crc_q       <= crc_n;
`endif
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: dut0 pads to 60 bytes, dut1 has padding disabled; expected nibbles go through a scoreboard queue.
module tb_mii_tx_framer;
    localparam int unsigned IFG = 24;

    logic       clk = 1'b0;
    logic       rst, valid, tx_last, sel;
    logic [7:0] tx_data;
    logic       v0, v1;
    logic       ready0, en0, busy0, und0, ready1, en1, busy1, und1;
    logic [3:0] txd0, txd1;
    logic       o_ready, o_en, o_busy, o_und;
    logic [3:0] o_txd;

    assign v0      = valid & ~sel;
    assign v1      = valid & sel;
    assign o_ready = sel ? ready1 : ready0;
    assign o_en    = sel ? en1 : en0;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_und   = sel ? und1 : und0;
    assign o_txd   = sel ? txd1 : txd0;

    always #5 clk = ~clk;

    mii_tx_framer #(.MIN_FRAME_BYTES(60), .IFG_NIBBLES(IFG)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(v0), .tx_last(tx_last),
        .tx_ready(ready0), .phy_tx_en(en0), .phy_txd(txd0), .tx_busy(busy0), .tx_underrun(und0)
    );

    mii_tx_framer #(.MIN_FRAME_BYTES(0), .IFG_NIBBLES(IFG)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(v1), .tx_last(tx_last),
        .tx_ready(ready1), .phy_tx_en(en1), .phy_txd(txd1), .tx_busy(busy1), .tx_underrun(und1)
    );

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q[$];
    logic [8:0] src_q[$];
    logic [7:0] frm[$];
    logic [3:0] ref_fcs[8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    bit         prev_en = 1'b0;
    bit         armed = 1'b0;
    int         low_run = 0;
    int         last_gap = -1;
    int         und_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reflected CRC-32
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ d[j];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic queue_frame(input int unsigned min_bytes, input bit complete, input bit use_ref);
        logic [31:0] crc;
        int unsigned n;
        crc = 32'hFFFFFFFF;
        n   = 0;
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 0; i < int'(frm.size()); i++) begin
            src_q.push_back({(complete && i == int'(frm.size()) - 1), frm[i]});
            exp_q.push_back(frm[i][3:0]);
            exp_q.push_back(frm[i][7:4]);
            crc = crc_model(crc, frm[i]);
            n++;
        end
        if (complete) begin
            while (n < min_bytes) begin
                exp_q.push_back(4'h0);
                exp_q.push_back(4'h0);
                crc = crc_model(crc, 8'h00);
                n++;
            end
`ifdef MII_TX_FCS_EN
            crc = ~crc;
            for (int k = 0; k < 8; k++) exp_q.push_back(use_ref ? ref_fcs[k] : crc[4*k +: 4]);
`endif
        end
    endtask

    // One clock: drive source, sample outputs #1 after the edge, score nibbles and gaps
    task automatic cycle();
        bit         take;
        logic [8:0] popped;
        logic [3:0] e;
        if (src_q.size() > 0) begin
            valid   = 1'b1;
            tx_data = src_q[0][7:0];
            tx_last = src_q[0][8];
        end else begin
            valid   = 1'b0;
            tx_data = 8'h00;
            tx_last = 1'b0;
        end
        take = o_ready && valid;
        @(posedge clk);
        #1;
        if (take) popped = src_q.pop_front();
        if (o_en) begin
            check("nibble_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("txd", 32'(o_txd), 32'(e));
            end
            check("busy_during_frame", 32'(o_busy), 32'd1);
            if (!prev_en && armed) last_gap = low_run;
            low_run = 0;
            armed   = 1'b1;
        end else begin
            check("txd_idle", 32'(o_txd), 32'd0);
            low_run++;
        end
        if (o_und) begin
            und_count++;
            check("underrun_shape", 32'({prev_en, o_en}), 32'd2);
        end
        prev_en = o_en;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0 || o_busy) && n < 4000) begin
            cycle();
            n++;
        end
        check({tag, "_in_time"}, 32'(n < 4000), 32'd1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        valid   = 1'b1;
        tx_data = 8'h5A;
        tx_last = 1'b1;
        sel     = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_tx_en", 32'(en0), 32'd0);
            check("rst_txd", 32'(txd0), 32'd0);
            check("rst_ready", 32'(ready0), 32'd0);
            check("rst_busy", 32'(busy0), 32'd0);
            check("rst_underrun", 32'(und0), 32'd0);
            check("rst_tx_en1", 32'(en1), 32'd0);
        end
        rst   = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(ready0), 32'd1);
        check("ready1_after_rst", 32'(ready1), 32'd1);
        check("no_transfer_in_rst", 32'({en0, busy0}), 32'd0);

        // Single-byte frame padded to 60 bytes
        frm.delete();
        frm.push_back(8'hAB);
        queue_frame(60, 1'b1, 1'b0);
        wait_done("min_frame");

        // 64-byte frame with a short frame queued behind it
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'(i * 3 + 1));
        queue_frame(60, 1'b1, 1'b0);
        frm.delete();
        for (int i = 0; i < 5; i++) frm.push_back(8'(8'hC0 + i));
        queue_frame(60, 1'b1, 1'b0);
        last_gap = -1;
        wait_done("back_to_back");
        check("b2b_gap", 32'(last_gap), 32'(IFG));

        // Source starves after byte 10 of a 64-byte frame
        frm.delete();
        for (int i = 0; i < 10; i++) frm.push_back(8'(8'h10 + i));
        queue_frame(60, 1'b0, 1'b0);
        n = 0;
        while (und_count == 0 && n < 2000) begin
            cycle();
            n++;
        end
        check("underrun_seen", 32'(und_count), 32'd1);
        check("underrun_drained", 32'(exp_q.size()), 32'd0);
        frm.delete();
        for (int i = 0; i < 3; i++) frm.push_back(8'(8'h70 + i));
        queue_frame(60, 1'b1, 1'b0);
        last_gap = -1;
        wait_done("after_underrun");
        check("underrun_gap", 32'(last_gap), 32'(IFG));

        // Padding disabled: CRC reference string, then a 4-byte frame
        sel   = 1'b1;
        armed = 1'b0;
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
        queue_frame(0, 1'b1, 1'b1);
        wait_done("crc_ref");
        frm.delete();
        for (int i = 1; i <= 4; i++) frm.push_back(8'(i));
        queue_frame(0, 1'b1, 1'b0);
        wait_done("short4");

        check("underrun_total", 32'(und_count), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
